// File: rtl/id_issue_pkg.sv
// Shared definitions for the id_issue decode/issue slice: instruction layout,
// register-file sizing and ALU operation encodings.
package id_issue_pkg;

    localparam int REG_NUM_DEF = 8;
    localparam int REG_AW      = 3;
    localparam int INSTR_W     = 16;

    localparam int IMMOP_BIT = 15;
    localparam int ALUOP_HI  = 14;
    localparam int ALUOP_LO  = 12;
    localparam int RD_HI     = 11;
    localparam int RD_LO     = 9;
    localparam int RS_HI     = 8;
    localparam int RS_LO     = 6;
    localparam int ABSEL_BIT = 5;
    localparam int IMM_HI    = 4;
    localparam int IMM_LO    = 0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } aluop_e;

    // Field order mirrors the bit positions above, so a plain cast decodes a word.
    typedef struct packed {
        logic              immop;
        logic [2:0]        aluop;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic              absel;
        logic [4:0]        imm5;
    } instr_t;

endpackage

// File: rtl/id_regfile.sv
// Register file for id_issue: two combinational read ports, one synchronous
// write port, r0 hardwired to zero, synchronous clear on rst.
module id_regfile #(
    parameter int WIDTH   = 16,
    parameter int REG_NUM = 8,
    parameter int AW      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] regs_r [REG_NUM];

    // Storage update: clear on reset, otherwise write any register except r0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en && (wr_addr != {AW{1'b0}})) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    assign ra_data = (ra_addr == {AW{1'b0}}) ? {WIDTH{1'b0}} : regs_r[ra_addr];
    assign rb_data = (rb_addr == {AW{1'b0}}) ? {WIDTH{1'b0}} : regs_r[rb_addr];

endmodule

// File: rtl/id_issue.sv
// Decode-and-issue stage: scoreboarded hazard stall, registered EX bundle, write-back port.
// Define ID_ISSUE_BYPASS_EN to forward a same-cycle write-back into the read operands.
module id_issue
    import id_issue_pkg::*;
#(
    parameter int CPU_WIDTH = 16,
    parameter int REG_NUM   = REG_NUM_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [CPU_WIDTH-1:0] ex_rd,
    output logic [CPU_WIDTH-1:0] ex_rs,
    output logic [CPU_WIDTH-1:0] ex_imm,
    output logic                 ex_absel,
    output logic                 ex_immop,
    output logic [2:0]           ex_aluop,
    output logic [REG_AW-1:0]    ex_dst,
    input  logic                 wb_en,
    input  logic [REG_AW-1:0]    wb_addr,
    input  logic [CPU_WIDTH-1:0] wb_data
);

    instr_t               instr_s;
    logic [CPU_WIDTH-1:0] ra_data_s;
    logic [CPU_WIDTH-1:0] rb_data_s;
    logic [CPU_WIDTH-1:0] op_a_s;
    logic [CPU_WIDTH-1:0] op_b_s;
    logic [CPU_WIDTH-1:0] imm_s;
    logic [REG_NUM-1:0]   pending_r;
    logic [REG_NUM-1:0]   pending_eff_s;
    logic [REG_NUM-1:0]   pending_nxt_s;
    logic                 hazard_s;
    logic                 accept_s;

    assign instr_s = instr_t'(in_instr);
    assign imm_s   = {{(CPU_WIDTH-5){instr_s.imm5[4]}}, instr_s.imm5};

    id_regfile #(
        .WIDTH   (CPU_WIDTH),
        .REG_NUM (REG_NUM),
        .AW      (REG_AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (instr_s.rd),
        .rb_addr (instr_s.rs),
        .ra_data (ra_data_s),
        .rb_data (rb_data_s),
        .wr_en   (wb_en),
        .wr_addr (wb_addr),
        .wr_data (wb_data)
    );

    // Pending view used by the hazard check and operand selection with optional forwarding.
    always_comb begin
        pending_eff_s = pending_r;
        op_a_s        = ra_data_s;
        op_b_s        = rb_data_s;
`ifdef ID_ISSUE_BYPASS_EN
        if (wb_en) begin
            pending_eff_s[wb_addr] = 1'b0;
        end else begin
            pending_eff_s = pending_r;
        end
        if (wb_en && (wb_addr == instr_s.rd) && (instr_s.rd != 3'd0)) begin
            op_a_s = wb_data;
        end else begin
            op_a_s = ra_data_s;
        end
        if (wb_en && (wb_addr == instr_s.rs) && (instr_s.rs != 3'd0)) begin
            op_b_s = wb_data;
        end else begin
            op_b_s = rb_data_s;
        end
`endif
    end

    // rd is checked too so a second writer to the same register waits (WAW).
    assign hazard_s = pending_eff_s[instr_s.rd] | pending_eff_s[instr_s.rs];
    assign in_ready = ~hazard_s & (~ex_valid | ex_ready);
    assign accept_s = in_valid & in_ready;

    // Scoreboard next state: write-back clears first so a same-cycle new writer wins.
    always_comb begin
        pending_nxt_s = pending_r;
        if (wb_en) begin
            pending_nxt_s[wb_addr] = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
        if (accept_s && (instr_s.rd != 3'd0)) begin
            pending_nxt_s[instr_s.rd] = 1'b1;
        end else begin
            pending_nxt_s[0] = 1'b0;
        end
        pending_nxt_s[0] = 1'b0;
    end

    // Scoreboard register and EX bundle register; bundle holds while EX stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= {REG_NUM{1'b0}};
            ex_valid  <= 1'b0;
            ex_rd     <= {CPU_WIDTH{1'b0}};
            ex_rs     <= {CPU_WIDTH{1'b0}};
            ex_imm    <= {CPU_WIDTH{1'b0}};
            ex_absel  <= 1'b0;
            ex_immop  <= 1'b0;
            ex_aluop  <= 3'd0;
            ex_dst    <= {REG_AW{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
            if (accept_s) begin
                ex_valid <= 1'b1;
                ex_rd    <= op_a_s;
                ex_rs    <= op_b_s;
                ex_imm   <= imm_s;
                ex_absel <= instr_s.absel;
                ex_immop <= instr_s.immop;
                ex_aluop <= instr_s.aluop;
                ex_dst   <= instr_s.rd;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_issue.sv
// Self-checking bench for id_issue: vector table plus hand sequences, with an
// expected-bundle queue filled on accept and drained on each EX handshake.
module tb_id_issue;

    logic        clk;
    logic        rst;
    logic [15:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic [15:0] ex_rd;
    logic [15:0] ex_rs;
    logic [15:0] ex_imm;
    logic        ex_absel;
    logic        ex_immop;
    logic [2:0]  ex_aluop;
    logic [2:0]  ex_dst;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;

    id_issue dut (
        .clk      (clk),
        .rst      (rst),
        .in_instr (in_instr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .ex_rd    (ex_rd),
        .ex_rs    (ex_rs),
        .ex_imm   (ex_imm),
        .ex_absel (ex_absel),
        .ex_immop (ex_immop),
        .ex_aluop (ex_aluop),
        .ex_dst   (ex_dst),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rd_v;
        logic [15:0] rs_v;
        logic [15:0] imm;
        logic        absel;
        logic        immop;
        logic [2:0]  aluop;
        logic [2:0]  dst;
    } bundle_t;

    typedef struct {
        logic        v;
        logic [15:0] ins;
        logic        rdy;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        exp_rdy;
    } vec_t;

`ifdef ID_ISSUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    int          total = 0;
    int          bad   = 0;
    int          step_no = 0;
    logic [15:0] reg_m [8];
    logic        exv_m;
    bundle_t     sb [$];
    vec_t        vecs [11];

    function automatic logic [15:0] mk(input logic immop, input logic [2:0] aluop,
                                       input logic [2:0] rd, input logic [2:0] rs,
                                       input logic absel, input logic [4:0] imm);
        return {immop, aluop, rd, rs, absel, imm};
    endfunction

    function automatic vec_t mkv(input logic v, input logic [15:0] ins, input logic rdy,
                                 input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                 input logic exp_rdy);
        vec_t t;
        t.v = v; t.ins = ins; t.rdy = rdy; t.we = we; t.wa = wa; t.wd = wd; t.exp_rdy = exp_rdy;
        return t;
    endfunction

    function automatic bundle_t expect_bundle(input logic [15:0] ins, input logic we,
                                              input logic [2:0] wa, input logic [15:0] wd);
        bundle_t    e;
        logic [2:0] a;
        logic [2:0] b;
        a = ins[11:9];
        b = ins[8:6];
        e.rd_v  = (a == 3'd0) ? 16'h0000 : reg_m[a];
        e.rs_v  = (b == 3'd0) ? 16'h0000 : reg_m[b];
`ifdef ID_ISSUE_BYPASS_EN
        if (we && a != 3'd0 && wa == a) e.rd_v = wd;
        if (we && b != 3'd0 && wa == b) e.rs_v = wd;
`endif
        e.imm   = {{11{ins[4]}}, ins[4:0]};
        e.absel = ins[5];
        e.immop = ins[15];
        e.aluop = ins[14:12];
        e.dst   = a;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive at edge+1, check at the falling edge, then update the model.
    task automatic step(input logic v, input logic [15:0] ins, input logic rdy,
                        input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic exp_rdy);
        bundle_t act;
        step_no++;
        in_valid = v;
        in_instr = v ? ins : 16'h0000;
        ex_ready = rdy;
        wb_en    = we;
        wb_addr  = wa;
        wb_data  = wd;
        @(negedge clk);
        chk($sformatf("in_ready[s%0d]", step_no), {63'd0, in_ready}, {63'd0, exp_rdy});
        chk($sformatf("ex_valid[s%0d]", step_no), {63'd0, ex_valid}, {63'd0, exv_m});
        if (exv_m) begin
            act = {ex_rd, ex_rs, ex_imm, ex_absel, ex_immop, ex_aluop, ex_dst};
            if (sb.size() == 0) begin
                bad++;
                total++;
                $display("FAIL scoreboard_empty[s%0d]: got bundle %0h expected none", step_no, act);
            end else begin
                chk($sformatf("bundle[s%0d]", step_no), {8'd0, act}, {8'd0, sb[0]});
                if (rdy) void'(sb.pop_front());
            end
        end
        if (v && exp_rdy) sb.push_back(expect_bundle(ins, we, wa, wd));
        exv_m = (v && exp_rdy) ? 1'b1 : (rdy ? 1'b0 : exv_m);
        if (we && wa != 3'd0) reg_m[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic we, input logic [2:0] wa, input logic [15:0] wd);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        ex_ready = 1'b0;
        wb_en    = we;
        wb_addr  = wa;
        wb_data  = wd;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wb_en = 1'b0;
        @(negedge clk);
        chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
        chk("rst_bundle", {8'd0, ex_rd, ex_rs, ex_imm, ex_absel, ex_immop, ex_aluop, ex_dst}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 8; i++) reg_m[i] = 16'h0000;
        exv_m = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] b_ins;
        logic [15:0] h_ins;

        vecs[0]  = mkv(1'b1, 16'h8A45,                               1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        vecs[1]  = mkv(1'b1, mk(1'b0, 3'd1, 3'd1, 3'd0, 1'b1, 5'h1F), 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        vecs[2]  = mkv(1'b0, 16'h0000,                               1'b1, 1'b1, 3'd5, 16'h0055, 1'b1);
        vecs[3]  = mkv(1'b0, 16'h0000,                               1'b1, 1'b1, 3'd1, 16'h0011, 1'b1);
        vecs[4]  = mkv(1'b1, mk(1'b0, 3'd2, 3'd5, 3'd1, 1'b0, 5'h03), 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        vecs[5]  = mkv(1'b0, 16'h0000,                               1'b1, 1'b1, 3'd0, 16'hBEEF, 1'b1);
        vecs[6]  = mkv(1'b1, mk(1'b0, 3'd5, 3'd2, 3'd0, 1'b1, 5'h10), 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        vecs[7]  = mkv(1'b1, mk(1'b0, 3'd6, 3'd0, 3'd0, 1'b0, 5'h01), 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        vecs[8]  = mkv(1'b1, mk(1'b1, 3'd7, 3'd4, 3'd0, 1'b0, 5'h02), 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        vecs[9]  = mkv(1'b0, 16'h0000,                               1'b1, 1'b1, 3'd2, 16'h2222, 1'b1);
        vecs[10] = mkv(1'b0, 16'h0000,                               1'b1, 1'b1, 3'd4, 16'h4444, 1'b1);

        do_reset(1'b0, 3'd0, 16'h0000);

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].v, vecs[i].ins, vecs[i].rdy, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].exp_rdy);
        end

        // RAW: writer of r2, then a reader of r2 stalls until r2 is written back.
        step(1'b1, mk(1'b0, 3'd1, 3'd2, 3'd4, 1'b0, 5'h07), 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        b_ins = mk(1'b0, 3'd2, 3'd7, 3'd2, 1'b0, 5'h00);
        step(1'b1, b_ins, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0);
        step(1'b1, b_ins, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0);
        step(1'b1, b_ins, 1'b1, 1'b1, 3'd2, 16'h1234, BYP);
`ifndef ID_ISSUE_BYPASS_EN
        step(1'b1, b_ins, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
`endif

        // Back-pressure: bundle held for three cycles, then one per cycle.
        step(1'b1, mk(1'b0, 3'd3, 3'd6, 3'd0, 1'b0, 5'h01), 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(1'b0, 3'd4, 3'd3, 3'd1, 1'b1, 5'h02), 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
        end
        step(1'b1, mk(1'b0, 3'd4, 3'd3, 3'd1, 1'b1, 5'h02), 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        step(1'b1, mk(1'b1, 3'd6, 3'd1, 3'd4, 1'b0, 5'h09), 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        step(1'b1, mk(1'b0, 3'd7, 3'd0, 3'd0, 1'b0, 5'h00), 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);

        // Accept setting pending[3] alongside a write-back clearing it: set must win.
        step(1'b0, 16'h0000, 1'b1, 1'b1, 3'd3, 16'h3333, 1'b1);
        step(1'b1, mk(1'b0, 3'd1, 3'd3, 3'd0, 1'b0, 5'h00), 1'b1, 1'b1, 3'd3, 16'h3030, 1'b1);
        h_ins = mk(1'b0, 3'd0, 3'd0, 3'd3, 1'b0, 5'h00);
        step(1'b1, h_ins, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0);
        step(1'b1, h_ins, 1'b1, 1'b1, 3'd3, 16'h0003, BYP);
`ifndef ID_ISSUE_BYPASS_EN
        step(1'b1, h_ins, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
`endif

        // Reset while a bundle is held; the write-back in the reset cycle is dropped.
        step(1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        step(1'b1, mk(1'b0, 3'd5, 3'd2, 3'd2, 1'b0, 5'h04), 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);
        do_reset(1'b1, 3'd6, 16'hDEAD);
        step(1'b1, mk(1'b0, 3'd2, 3'd7, 3'd5, 1'b0, 5'h00), 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        step(1'b1, mk(1'b0, 3'd3, 3'd6, 3'd1, 1'b0, 5'h00), 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
